// File: rtl/reg_bank_scanner.sv
// ---------------------------------------------------------------------------
// reg_bank_scanner
//
// 32 x 8-bit register bank plus a scan sequencer that feeds an external
// 8-bit 32:1 output mux. The bank drives the mux data inputs through
// regs_flat. The sequencer drives the mux select. It walks select over an
// index window and holds each index for DWELL cycles. valid marks the last
// cycle of each dwell, when the mux output has settled.
//
// Parameters
//   DWELL     cycles select is held per index (1..255)
//   RST_VAL   reset value of every register
//
// Ports
//   clk        in   1    rising-edge clock
//   resetn     in   1    synchronous active-low reset
//   wr_en      in   1    register write strobe
//   wr_addr    in   5    register index to write
//   wr_data    in   8    write data
//   start      in   1    scan request, honoured only in IDLE
//   first      in   5    first index of window, latched on accepted start
//   last       in   5    last index of window, latched on accepted start
//   loop       in   1    continuous-scan request (SCAN_LOOP_EN builds only)
//   regs_flat  out  256  register k on bits [8k+7:8k]
//   select     out  5    mux select
//   valid      out  1    mux output stable this cycle
//   busy       out  1    high while in SCAN
//   done       out  1    one-cycle pulse at scan completion
//
// Build option
//   SCAN_LOOP_EN  adds the loop port. When the last index of a pass ends and
//                 loop is high, the scan restarts at the latched first index
//                 and does not pulse done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; select holds its last value
// SCAN  | walking the window; dwell_cnt counts 0..DWELL-1 per index
// DONE  | done pulse cycle; select holds last; returns to IDLE
// ---------------------------------------------------------------------------
module reg_bank_scanner #(
    parameter int         DWELL   = 4,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [7:0]   wr_data,
    input  logic         start,
    input  logic [4:0]   first,
    input  logic [4:0]   last,
`ifdef SCAN_LOOP_EN
    input  logic         loop,
`endif
    output logic [255:0] regs_flat,
    output logic [4:0]   select,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
    // With a one-cycle dwell, every cycle spent on an index is its last cycle.
    localparam logic       VALID_ON_ENTRY = (DWELL == 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] regs [32];
    logic [7:0] dwell_cnt;
    logic [4:0] last_q;
`ifdef SCAN_LOOP_EN
    logic [4:0] first_q;
`endif

    for (genvar k = 0; k < 32; k++) begin : g_flat
        assign regs_flat[8*k +: 8] = regs[k];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int k = 0; k < 32; k++) begin
                regs[k] <= RST_VAL;
            end
            state     <= ST_IDLE;
            select    <= 5'd0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dwell_cnt <= 8'd0;
            last_q    <= 5'd0;
`ifdef SCAN_LOOP_EN
            first_q   <= 5'd0;
`endif
        end else begin
            // Host writes are accepted in every state, including on the index
            // currently under scan.
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
            end

            done <= 1'b0;

            case (state)
                ST_IDLE: begin
                    valid <= 1'b0;
                    if (start) begin
                        last_q    <= last;
`ifdef SCAN_LOOP_EN
                        first_q   <= first;
`endif
                        select    <= first;
                        dwell_cnt <= 8'd0;
                        valid     <= VALID_ON_ENTRY;
                        busy      <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (dwell_cnt == DWELL_LAST) begin
                        dwell_cnt <= 8'd0;
                        if (select == last_q) begin
`ifdef SCAN_LOOP_EN
                            if (loop) begin
                                select <= first_q;
                                valid  <= VALID_ON_ENTRY;
                            end else
`endif
                            begin
                                valid <= 1'b0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end
                        end else begin
                            // 5-bit add wraps 31 -> 0 for windows with first > last.
                            select <= select + 5'd1;
                            valid  <= VALID_ON_ENTRY;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 8'd1;
                        valid     <= ((dwell_cnt + 8'd1) == DWELL_LAST);
                    end
                end

                ST_DONE: begin
                    valid <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_scanner.sv
module tb_reg_bank_scanner;

    logic         clk = 1'b0;
    logic         resetn;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [7:0]   wr_data;
    logic         start;
    logic         start1;
    logic [4:0]   first;
    logic [4:0]   last;
    logic         loop;
    logic [255:0] regs_flat, regs_flat1;
    logic [4:0]   select, select1;
    logic         valid, valid1;
    logic         busy, busy1;
    logic         done, done1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_bank_scanner #(.DWELL(4), .RST_VAL(8'h00)) dut (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start), .first(first), .last(last),
`ifdef SCAN_LOOP_EN
        .loop(loop),
`endif
        .regs_flat(regs_flat), .select(select), .valid(valid),
        .busy(busy), .done(done)
    );

    // Second instance exercises the single-cycle dwell corner.
    reg_bank_scanner #(.DWELL(1), .RST_VAL(8'h00)) dut1 (
        .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .start(start1), .first(first), .last(last),
`ifdef SCAN_LOOP_EN
        .loop(1'b0),
`endif
        .regs_flat(regs_flat1), .select(select1), .valid(valid1),
        .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts a scan on dut (DWELL=4) and checks every cycle up to and past done.
    task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input int len, input bit mid);
        int n_valid;
        n_valid = 0;
        first = f; last = l; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < len * 4; i++) begin
            check("scan_sel",   32'(select), 32'(5'(f + i / 4)));
            check("scan_busy",  32'(busy),   32'd1);
            check("scan_valid", 32'(valid),  32'((i % 4) == 3));
            check("scan_done",  32'(done),   32'd0);
            if (valid) n_valid++;
            if (mid && i == 5) begin
                start = 1'b1; first = 5'd10; last = 5'd12;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        check("valid_count", 32'(n_valid), 32'(len));
        check("end_done",  32'(done),   32'd1);
        check("end_busy",  32'(busy),   32'd0);
        check("end_valid", 32'(valid),  32'd0);
        check("end_sel",   32'(select), 32'(l));
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        tick();
        check("no_queue_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start1 = 1'b0; first = '0; last = '0; loop = 1'b0;
        #2;
        tick();
        tick();
        check("rst_sel",   32'(select), 32'd0);
        check("rst_valid", 32'(valid),  32'd0);
        check("rst_busy",  32'(busy),   32'd0);
        check("rst_done",  32'(done),   32'd0);
        check("rst_reg0",  32'(regs_flat[7:0]),     32'h00);
        check("rst_reg31", 32'(regs_flat[255:248]), 32'h00);
        resetn = 1'b1;
        tick();

        // Fill bank with k+0x40
        for (int k = 0; k < 32; k++) begin
            wr_en = 1'b1; wr_addr = 5'(k); wr_data = 8'(k + 8'h40);
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check("fill", 32'(regs_flat[8*k +: 8]), 32'(8'h40 + k));
        end
        check("fill_hi", 32'(regs_flat[255:248]), 32'h5F);

        run_scan(5'd3, 5'd6, 4, 1'b0);
        run_scan(5'd30, 5'd1, 4, 1'b1);

        // Write the index under scan; new data visible before that dwell's valid.
        first = 5'd5; last = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        check("wr_scan_data",  32'(regs_flat[47:40]), 32'hA5);
        check("wr_scan_valid", 32'(valid),  32'd0);
        check("wr_scan_sel",   32'(select), 32'd5);
        tick();
        tick();
        check("wr_scan_valid_end", 32'(valid), 32'd1);
        check("wr_scan_data_end",  32'(regs_flat[47:40]), 32'hA5);
        tick();
        check("wr_scan_done", 32'(done), 32'd1);
        tick();

        // DWELL=1: select advances and valid is high every scan cycle.
        first = 5'd2; last = 5'd4; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("d1_sel",   32'(select1), 32'(2 + i));
            check("d1_valid", 32'(valid1),  32'd1);
            check("d1_busy",  32'(busy1),   32'd1);
            tick();
        end
        check("d1_done", 32'(done1), 32'd1);
        check("d1_busy_end", 32'(busy1), 32'd0);
        tick();

`ifdef SCAN_LOOP_EN
        loop = 1'b1; first = 5'd0; last = 5'd1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            check("loop_sel",  32'(select), 32'((i / 4) % 2));
            check("loop_done", 32'(done),   32'd0);
            check("loop_busy", 32'(busy),   32'd1);
            if (i == 25) loop = 1'b0;
            tick();
        end
        check("loop_end_done", 32'(done), 32'd1);
        check("loop_end_sel",  32'(select), 32'd1);
        tick();
        check("loop_idle", 32'(busy), 32'd0);
`endif

        // Reset mid-scan aborts and clears the bank.
        first = 5'd0; last = 5'd31; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        tick();
        check("mrst_sel",   32'(select), 32'd0);
        check("mrst_busy",  32'(busy),   32'd0);
        check("mrst_valid", 32'(valid),  32'd0);
        check("mrst_done",  32'(done),   32'd0);
        check("mrst_reg5",  32'(regs_flat[47:40]), 32'h00);
        check("mrst_reg31", 32'(regs_flat[255:248]), 32'h00);
        resetn = 1'b1;
        tick();
        check("mrst_done2", 32'(done), 32'd0);
        check("mrst_busy2", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
